// File: rtl/ps2_keyboard_rx_if.sv
// PS/2 keyboard receiver bundle: raw pins in, decoded key level and strobes out.
interface ps2_keyboard_rx_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_event;
    logic       key_break;
    logic       frame_err;

    // Receiver side: samples the pins, produces key information.
    modport master (
        input  ps2_clk,
        input  ps2_data,
        output key_code,
        output key_ext,
        output key_event,
        output key_break,
        output frame_err
    );

    // Board / consumer side: drives the pins, reads key information.
    modport slave (
        output ps2_clk,
        output ps2_data,
        input  key_code,
        input  key_ext,
        input  key_event,
        input  key_break,
        input  frame_err
    );
endinterface

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: pin synchronizers, ps2_clk glitch filter, 11-bit frame
// FSM with mid-frame timeout, and scan-code set 2 make/break (F0/E0) decoder.
module ps2_keyboard_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 25000
) (
    input  logic              clk,
    input  logic              reset,
    ps2_keyboard_rx_if.master bus
);
    localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // Pin 0 = ps2_clk, pin 1 = ps2_data; both idle high on the bus.
    logic [1:0] pin_raw;
    logic [1:0] pin_sync;
    assign pin_raw = {bus.ps2_data, bus.ps2_clk};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;
            // Two-flop synchronizer for an asynchronous pin.
            always_ff @(posedge clk) begin
                if (reset) begin
                    meta_reg <= 1'b1;
                    sync_reg <= 1'b1;
                end else begin
                    meta_reg <= pin_raw[gi];
                    sync_reg <= meta_reg;
                end
            end
            assign pin_sync[gi] = sync_reg;
        end
    endgenerate

    logic clk_sync;
    logic data_sync;
    assign clk_sync  = pin_sync[0];
    assign data_sync = pin_sync[1];

    logic           filt_reg;
    logic           filt_d_reg;
    logic [FCW-1:0] fcnt_reg;
    logic           fall;

    // Glitch filter: follow the synchronized clock only after FILTER_LEN
    // consecutive samples disagree with the current filtered value.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_reg   <= 1'b1;
            filt_d_reg <= 1'b1;
            fcnt_reg   <= '0;
        end else begin
            filt_d_reg <= filt_reg;
            if (clk_sync == filt_reg) begin
                fcnt_reg <= '0;
            end else if (fcnt_reg == FCW'(FILTER_LEN - 1)) begin
                filt_reg <= clk_sync;
                fcnt_reg <= '0;
            end else begin
                fcnt_reg <= fcnt_reg + 1'b1;
            end
        end
    end

    assign fall = filt_d_reg & ~filt_reg;

    logic [0:0]     state_reg;
    logic [3:0]     bit_cnt_reg;
    logic [8:0]     shift_reg;
    logic [TCW-1:0] to_cnt_reg;
    logic           brk_reg;
    logic           ext_reg;
    logic [7:0]     key_code_reg;
    logic           key_ext_reg;
    logic           key_event_reg;
    logic           key_break_reg;
    logic           frame_err_reg;

    // At the stop-bit fall shift_reg holds {parity, data[7:0]}.
    logic [7:0] rx_byte;
    logic       frame_ok;
    assign rx_byte  = shift_reg[7:0];
    assign frame_ok = (^shift_reg) & data_sync;

    // Frame reception, timeout supervision and scan-code decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            to_cnt_reg    <= '0;
            brk_reg       <= 1'b0;
            ext_reg       <= 1'b0;
            key_code_reg  <= 8'h00;
            key_ext_reg   <= 1'b0;
            key_event_reg <= 1'b0;
            key_break_reg <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            key_event_reg <= 1'b0;
            key_break_reg <= 1'b0;
            frame_err_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (fall && !data_sync) begin
                        state_reg   <= ST_SHIFT;
                        bit_cnt_reg <= '0;
                        to_cnt_reg  <= TCW'(1);
                    end
                end
                ST_SHIFT: begin
                    if (fall) begin
                        to_cnt_reg <= TCW'(1);
                        if (bit_cnt_reg == 4'd9) begin
                            state_reg <= ST_IDLE;
                            if (!frame_ok) begin
                                frame_err_reg <= 1'b1;
                                brk_reg       <= 1'b0;
                                ext_reg       <= 1'b0;
                            end else if (rx_byte == 8'hF0) begin
                                brk_reg <= 1'b1;
                            end else if (rx_byte == 8'hE0) begin
                                ext_reg <= 1'b1;
                            end else begin
                                key_event_reg <= 1'b1;
                                brk_reg       <= 1'b0;
                                ext_reg       <= 1'b0;
                                if (brk_reg) begin
                                    // Releasing a key other than the held one leaves the level alone.
                                    key_break_reg <= 1'b1;
                                    if (rx_byte == key_code_reg) begin
                                        key_code_reg <= 8'h00;
                                        key_ext_reg  <= 1'b0;
                                    end
                                end else begin
                                    key_code_reg <= rx_byte;
                                    key_ext_reg  <= ext_reg;
                                end
                            end
                        end else begin
                            shift_reg   <= {data_sync, shift_reg[8:1]};
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        end
                    end else if (to_cnt_reg == TCW'(TIMEOUT_CYCLES - 1)) begin
                        frame_err_reg <= 1'b1;
                        state_reg     <= ST_IDLE;
                        brk_reg       <= 1'b0;
                        ext_reg       <= 1'b0;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.key_code  = key_code_reg;
    assign bus.key_ext   = key_ext_reg;
    assign bus.key_event = key_event_reg;
    assign bus.key_break = key_break_reg;
    assign bus.frame_err = frame_err_reg;
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Bench for ps2_keyboard_rx: table of frames with expected levels, scoreboard of
// expected strobes (with latency from the driven fall), plus timeout, glitch and
// mid-frame reset sequences.
module tb_ps2_keyboard_rx;
    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 4500;
    localparam int HALF       = 50;
    localparam int EV_LAT     = FILTER_LEN + 3;
    localparam int TO_LAT     = FILTER_LEN + 2 + TIMEOUT;

    logic clk;
    logic reset;
    int   cyc;
    int   last_fall_cyc;
    int   errors;
    int   checks;

    ps2_keyboard_rx_if bus_if ();

    ps2_keyboard_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         err;
        logic [7:0] code;
        bit         ext;
        bit         brk;
        int         lat;
    } exp_t;

    typedef struct {
        logic [7:0] b;
        bit         bad;
        int         half;
        bit         ev;
        bit         err;
        bit         brk;
        logic [7:0] code;
        bit         ext;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: %0h (cycle %0d)", name, act, cyc);
        end
    endtask

    function automatic logic [10:0] frame(input logic [7:0] b, input bit bad);
        logic p;
        p = bad ? (^b) : ~(^b);
        return {1'b1, p, b, 1'b0};
    endfunction

    task automatic push(input bit err, input logic [7:0] code, input bit ext, input bit brk, input int lat);
        exp_t e;
        e.err = err; e.code = code; e.ext = ext; e.brk = brk; e.lat = lat;
        sb_q.push_back(e);
    endtask

    // Drives nbits of a frame, LSB first; data changes while ps2_clk is high.
    task automatic send_bits(input logic [10:0] bits, input int nbits, input int half, input int glitch_bit);
        for (int i = 0; i < nbits; i++) begin
            bus_if.ps2_data = bits[i];
            if (i == glitch_bit) begin
                repeat (half / 2) @(negedge clk);
                bus_if.ps2_clk = 1'b0;
                repeat (3) @(negedge clk);
                bus_if.ps2_clk = 1'b1;
                repeat (half - half / 2 - 3) @(negedge clk);
            end else begin
                repeat (half) @(negedge clk);
            end
            bus_if.ps2_clk = 1'b0;
            last_fall_cyc  = cyc;
            repeat (half) @(negedge clk);
            bus_if.ps2_clk = 1'b1;
        end
        bus_if.ps2_data = 1'b1;
    endtask

    // Strobe monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus_if.key_event && bus_if.frame_err)
                chk("event_and_err_together", 1, 0);
            if (bus_if.key_event || bus_if.frame_err) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_strobe", {bus_if.key_event, bus_if.frame_err}, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("strobe_is_err", bus_if.frame_err, e.err);
                    chk("strobe_latency", cyc - last_fall_cyc, e.lat);
                    if (!e.err) begin
                        chk("event_code", bus_if.key_code, e.code);
                        chk("event_ext", bus_if.key_ext, e.ext);
                        chk("event_break", bus_if.key_break, e.brk);
                    end
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        errors = 0; checks = 0; cyc = 0; last_fall_cyc = 0;
        bus_if.ps2_clk  = 1'b1;
        bus_if.ps2_data = 1'b1;
        reset = 1'b1;

        tbl[0]  = '{8'h1B, 0, 2000, 1, 0, 0, 8'h1B, 0};
        tbl[1]  = '{8'hF0, 0, HALF, 0, 0, 0, 8'h1B, 0};
        tbl[2]  = '{8'h1B, 0, HALF, 1, 0, 1, 8'h00, 0};
        tbl[3]  = '{8'hE0, 0, HALF, 0, 0, 0, 8'h00, 0};
        tbl[4]  = '{8'h75, 0, HALF, 1, 0, 0, 8'h75, 1};
        tbl[5]  = '{8'hE0, 0, HALF, 0, 0, 0, 8'h75, 1};
        tbl[6]  = '{8'hF0, 0, HALF, 0, 0, 0, 8'h75, 1};
        tbl[7]  = '{8'h75, 0, HALF, 1, 0, 1, 8'h00, 0};
        tbl[8]  = '{8'h1B, 0, HALF, 1, 0, 0, 8'h1B, 0};
        tbl[9]  = '{8'h4D, 1, HALF, 0, 1, 0, 8'h1B, 0};
        tbl[10] = '{8'h76, 0, HALF, 1, 0, 0, 8'h76, 0};
        tbl[11] = '{8'h76, 0, HALF, 1, 0, 0, 8'h76, 0};
        tbl[12] = '{8'h4D, 0, HALF, 1, 0, 0, 8'h4D, 0};
        tbl[13] = '{8'hF0, 0, HALF, 0, 0, 0, 8'h4D, 0};
        tbl[14] = '{8'h76, 0, HALF, 1, 0, 1, 8'h4D, 0};
        tbl[15] = '{8'hF0, 0, HALF, 0, 0, 0, 8'h4D, 0};
        tbl[16] = '{8'h4D, 0, HALF, 1, 0, 1, 8'h00, 0};

        repeat (5) @(negedge clk);
        chk("reset_key_code", bus_if.key_code, 8'h00);
        chk("reset_key_ext", bus_if.key_ext, 0);
        chk("reset_key_event", bus_if.key_event, 0);
        chk("reset_key_break", bus_if.key_break, 0);
        chk("reset_frame_err", bus_if.frame_err, 0);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        for (int i = 0; i < 17; i++) begin
            if (tbl[i].ev)  push(0, tbl[i].code, tbl[i].ext, tbl[i].brk, EV_LAT);
            if (tbl[i].err) push(1, 8'h00, 0, 0, EV_LAT);
            send_bits(frame(tbl[i].b, tbl[i].bad), 11, tbl[i].half, -1);
            repeat (20) @(negedge clk);
            chk($sformatf("tbl%0d_key_code", i), bus_if.key_code, tbl[i].code);
            chk($sformatf("tbl%0d_key_ext", i), bus_if.key_ext, tbl[i].ext);
        end

        // Pending F0, then a frame that stops after start + 4 data bits.
        send_bits(frame(8'hF0, 0), 11, HALF, -1);
        repeat (20) @(negedge clk);
        push(1, 8'h00, 0, 0, TO_LAT);
        send_bits(frame(8'h2D, 0), 5, HALF, -1);
        for (int k = 0; k < TIMEOUT + 200 && sb_q.size() != 0; k++) @(negedge clk);
        chk("timeout_err_seen", sb_q.size(), 0);
        chk("timeout_key_code", bus_if.key_code, 8'h00);
        repeat (20) @(negedge clk);
        push(0, 8'h2D, 0, 0, EV_LAT);
        send_bits(frame(8'h2D, 0), 11, HALF, -1);
        repeat (20) @(negedge clk);
        chk("after_timeout_key_code", bus_if.key_code, 8'h2D);

        // 3-cycle low glitch on ps2_clk in the middle of a bit.
        push(0, 8'h1B, 0, 0, EV_LAT);
        send_bits(frame(8'h1B, 0), 11, HALF, 4);
        repeat (20) @(negedge clk);
        chk("glitch_key_code", bus_if.key_code, 8'h1B);

        // Reset while bit 5 is in progress (clock high phase).
        send_bits(frame(8'h76, 0), 6, HALF, -1);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("midreset_key_code", bus_if.key_code, 8'h00);
        chk("midreset_key_ext", bus_if.key_ext, 0);
        chk("midreset_key_event", bus_if.key_event, 0);
        chk("midreset_key_break", bus_if.key_break, 0);
        chk("midreset_frame_err", bus_if.frame_err, 0);
        repeat (20) @(negedge clk);
        push(0, 8'h2D, 0, 0, EV_LAT);
        send_bits(frame(8'h2D, 0), 11, HALF, -1);
        repeat (50) @(negedge clk);
        chk("after_reset_key_code", bus_if.key_code, 8'h2D);
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
